// File: rtl/mc_datapath.sv
// Datapath of the multi-cycle CPU: PC/IR/DR/A/B/C, 32x32 register file, ALU,
// PC-next adders and memory-address mux, steered by control-unit strobes.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WritePC,
  input  logic        IorD,
  input  logic        WriteMem,
  input  logic        WriteDR,
  input  logic        WriteIR,
  input  logic        MemToReg,
  input  logic        RegDst,
  input  logic        WriteC,
  input  logic        ALUSrcA,
  input  logic        ALUSrcB,
  input  logic        WriteA,
  input  logic        WriteB,
  input  logic        WriteReg,
  input  logic [1:0]  PCSource,
  input  logic [2:0]  ALUC,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        Zero,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data,
  output logic [31:0] pc_out
);

  logic [31:0] pc, ir, dr, a, b, c;
  logic [31:0] rf [32];

  logic [31:0] imm_sext;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [31:0] pc_next;
  logic [4:0]  rf_dst;
  logic [31:0] rf_wdata;

  function automatic logic [31:0] alu_op(input logic [2:0]  sel,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
    logic signed [31:0] xs, ys;
    xs = x;
    ys = y;
    case (sel)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return {31'b0, (xs < ys)};
      3'b100:  return ~(x | y);
      3'b011:  return y << x[4:0];
      3'b101:  return y >> x[4:0];
      default: return '0;
    endcase
  endfunction

  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign alu_a    = ALUSrcA ? {27'b0, ir[10:6]} : a;
  assign alu_b    = ALUSrcB ? imm_sext : b;
  assign alu_res  = alu_op(ALUC, alu_a, alu_b);
  assign Zero     = (alu_res == 32'd0);

  // Branch target is relative to the already-incremented PC.
  always_comb begin
    pc_next = pc + 32'd4;
    case (PCSource)
      2'b00: pc_next = pc + 32'd4;
      2'b01: pc_next = pc + {imm_sext[29:0], 2'b00};
      2'b10: pc_next = {pc[31:28], ir[25:0], 2'b00};
      2'b11: pc_next = a;
      default: pc_next = pc + 32'd4;
    endcase
  end

  assign rf_dst   = RegDst ? ir[15:11] : ir[20:16];
  assign rf_wdata = MemToReg ? dr : c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= '0;
      dr <= '0;
      a  <= '0;
      b  <= '0;
      c  <= '0;
    end else begin
      if (WritePC) pc <= pc_next;
      if (WriteIR) ir <= mem_rdata;
      if (WriteDR) dr <= mem_rdata;
      if (WriteA)  a  <= rf[ir[25:21]];
      if (WriteB)  b  <= rf[ir[20:16]];
      if (WriteC)  c  <= alu_res;
    end
  end

  // No write bypass: same-cycle readers see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (WriteReg && (rf_dst != 5'd0)) begin
      rf[rf_dst] <= rf_wdata;
    end
  end

  assign mem_addr  = IorD ? c : pc;
  assign mem_wdata = b;
  assign mem_we    = WriteMem;
  assign op        = ir[31:26];
  assign func      = ir[5:0];
  assign dbg_data  = (dbg_sel == 5'd0) ? 32'd0 : rf[dbg_sel];
  assign pc_out    = pc;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: instruction sequences, ALU vector table and random
// control streams checked against an architectural model of the datapath.
module tb_mc_datapath;

  logic        clk;
  logic        rst;
  logic        WritePC, IorD, WriteMem, WriteDR, WriteIR, MemToReg, RegDst;
  logic        WriteC, ALUSrcA, ALUSrcB, WriteA, WriteB, WriteReg;
  logic [1:0]  PCSource;
  logic [2:0]  ALUC;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [5:0]  op, func;
  logic        Zero;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data, pc_out;

  mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .WritePC(WritePC), .IorD(IorD), .WriteMem(WriteMem), .WriteDR(WriteDR),
    .WriteIR(WriteIR), .MemToReg(MemToReg), .RegDst(RegDst), .WriteC(WriteC),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .WriteA(WriteA), .WriteB(WriteB),
    .WriteReg(WriteReg), .PCSource(PCSource), .ALUC(ALUC),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .op(op), .func(func), .Zero(Zero),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wpc, iord, wmem, wdr, wir, m2r, rdst, wc, srca, srcb, wa, wb, wreg;
    logic [1:0] pcs;
    logic [2:0] aluc;
  } ctl_t;

  typedef struct {
    logic [31:0] ir;
    logic [2:0]  aluc;
    logic [31:0] res;
  } alu_vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Architectural state of the reference model.
  logic [31:0] m_pc, m_ir, m_dr, m_a, m_b, m_c;
  logic [31:0] m_rf [32];
  bit          model_ok = 0;

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    case (f)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x + y;
      3'd6: return x - y;
      3'd7: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd4: return ~(x | y);
      3'd3: return y << x[4:0];
      default: return y >> x[4:0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_alu();
    logic [31:0] x, y;
    x = ALUSrcA ? {27'b0, m_ir[10:6]} : m_a;
    y = ALUSrcB ? sx(m_ir[15:0]) : m_b;
    return ref_alu(ALUC, x, y);
  endfunction

  task automatic drive(input ctl_t k, input logic [31:0] rd, input logic r);
    @(negedge clk);
    rst = r;
    WritePC = k.wpc; IorD = k.iord; WriteMem = k.wmem; WriteDR = k.wdr;
    WriteIR = k.wir; MemToReg = k.m2r; RegDst = k.rdst; WriteC = k.wc;
    ALUSrcA = k.srca; ALUSrcB = k.srcb; WriteA = k.wa; WriteB = k.wb;
    WriteReg = k.wreg; PCSource = k.pcs; ALUC = k.aluc; mem_rdata = rd;
    #1;
    if (model_ok) begin
      chk("mem_addr", mem_addr, IorD ? m_c : m_pc);
      chk("mem_wdata", mem_wdata, m_b);
      chk("mem_we", {31'b0, mem_we}, {31'b0, WriteMem});
      chk("op", {26'b0, op}, {26'b0, m_ir[31:26]});
      chk("func", {26'b0, func}, {26'b0, m_ir[5:0]});
      chk("Zero", {31'b0, Zero}, {31'b0, model_alu() == 32'd0});
      chk("dbg_data", dbg_data, (dbg_sel == 5'd0) ? 32'd0 : m_rf[dbg_sel]);
      chk("pc_out", pc_out, m_pc);
    end
  endtask

  task automatic tick();
    logic [31:0] res, npc, wd, na, nb;
    logic [4:0]  dst;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_ir = '0; m_dr = '0; m_a = '0; m_b = '0; m_c = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      model_ok = 1;
    end else begin
      res = model_alu();
      na  = m_rf[m_ir[25:21]];
      nb  = m_rf[m_ir[20:16]];
      case (PCSource)
        2'd0: npc = m_pc + 32'd4;
        2'd1: npc = m_pc + sx(m_ir[15:0]) * 4;
        2'd2: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: npc = m_a;
      endcase
      dst = RegDst ? m_ir[15:11] : m_ir[20:16];
      wd  = MemToReg ? m_dr : m_c;
      if (WriteReg && dst != 5'd0) m_rf[dst] = wd;
      if (WriteA)  m_a  = na;
      if (WriteB)  m_b  = nb;
      if (WriteC)  m_c  = res;
      if (WritePC) m_pc = npc;
      if (WriteDR) m_dr = mem_rdata;
      if (WriteIR) m_ir = mem_rdata;
    end
    #1;
  endtask

  task automatic cyc(input ctl_t k, input logic [31:0] rd);
    drive(k, rd, 1'b0);
    tick();
  endtask

  task automatic peek(input logic [4:0] sel);
    dbg_sel = sel;
    #1;
  endtask

  function automatic ctl_t c_fetch();
    ctl_t k = '0;
    k.wir = 1; k.wpc = 1; k.pcs = 2'b00;
    return k;
  endfunction

  function automatic ctl_t c_decode();
    ctl_t k = '0;
    k.wa = 1; k.wb = 1;
    return k;
  endfunction

  function automatic ctl_t c_exec(input logic imm, input logic [2:0] f);
    ctl_t k = '0;
    k.srcb = imm; k.aluc = f; k.wc = 1;
    return k;
  endfunction

  function automatic ctl_t c_wb(input logic rdst, input logic m2r);
    ctl_t k = '0;
    k.wreg = 1; k.rdst = rdst; k.m2r = m2r;
    return k;
  endfunction

  task automatic run_addi(input logic [31:0] instr);
    cyc(c_fetch(), instr);
    cyc(c_decode(), 32'h0);
    cyc(c_exec(1'b1, 3'b010), 32'h0);
    cyc(c_wb(1'b0, 1'b0), 32'h0);
  endtask

  task automatic jump_via(input logic [31:0] instr);
    ctl_t k;
    cyc(c_fetch(), instr);
    k = '0; k.wpc = 1; k.pcs = 2'b10;
    cyc(k, 32'h0);
  endtask

  alu_vec_t tv [18];
  ctl_t     k;
  logic [17:0] rv;

  initial begin
    tv[0]  = '{32'h0000_8143, 3'b000, 32'h0000_0001};
    tv[1]  = '{32'h0000_8143, 3'b001, 32'hFFFF_8147};
    tv[2]  = '{32'h0000_8143, 3'b010, 32'hFFFF_8148};
    tv[3]  = '{32'h0000_8143, 3'b110, 32'h0000_7EC2};
    tv[4]  = '{32'h0000_8143, 3'b111, 32'h0000_0000};
    tv[5]  = '{32'h0000_8143, 3'b100, 32'h0000_7EB8};
    tv[6]  = '{32'h0000_8143, 3'b011, 32'hFFF0_2860};
    tv[7]  = '{32'h0000_8143, 3'b101, 32'h07FF_FC0A};
    tv[8]  = '{32'h0000_0000, 3'b110, 32'h0000_0000};
    tv[9]  = '{32'h0000_0000, 3'b100, 32'hFFFF_FFFF};
    tv[10] = '{32'h0000_7FC0, 3'b011, 32'h0000_0000};
    tv[11] = '{32'h0000_7FC0, 3'b101, 32'h0000_0000};
    tv[12] = '{32'h0000_7FC0, 3'b111, 32'h0000_0001};
    tv[13] = '{32'h0000_7FC0, 3'b110, 32'hFFFF_805F};
    tv[14] = '{32'h0000_FFFF, 3'b010, 32'h0000_001E};
    tv[15] = '{32'h0000_FFFF, 3'b111, 32'h0000_0000};
    tv[16] = '{32'h0000_FFFF, 3'b101, 32'h0000_0001};
    tv[17] = '{32'h0000_FFFF, 3'b100, 32'h0000_0000};

    rst = 1'b1; dbg_sel = '0; mem_rdata = '0;
    WritePC = 0; IorD = 0; WriteMem = 0; WriteDR = 0; WriteIR = 0; MemToReg = 0;
    RegDst = 0; WriteC = 0; ALUSrcA = 0; ALUSrcB = 0; WriteA = 0; WriteB = 0;
    WriteReg = 0; PCSource = '0; ALUC = '0;

    // Reset with every strobe high for two edges.
    k = '1;
    drive(k, 32'hFFFF_FFFF, 1'b1); tick();
    drive(k, 32'hFFFF_FFFF, 1'b1); tick();
    chk("reset_pc", pc_out, 32'h0);
    for (int s = 0; s < 32; s++) begin
      peek(5'(s));
      chk("reset_rf", dbg_data, 32'h0);
    end
    k = '0;
    drive(k, 32'h0, 1'b0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_op", {26'b0, op}, 32'h0);
    tick();

    // Fetch.
    cyc(c_fetch(), 32'h2001_0005);
    chk("fetch_op", {26'b0, op}, 32'h0000_0008);
    chk("fetch_pc", pc_out, 32'h4);

    // addi $1,$0,5 ; addi $2,$0,7 ; add $3,$1,$2
    cyc(c_decode(), 32'h0);
    cyc(c_exec(1'b1, 3'b010), 32'h0);
    cyc(c_wb(1'b0, 1'b0), 32'h0);
    peek(5'd1); chk("addi_rf1", dbg_data, 32'd5);
    run_addi(32'h2002_0007);
    peek(5'd2); chk("addi_rf2", dbg_data, 32'd7);
    cyc(c_fetch(), 32'h0022_1820);
    chk("add_func", {26'b0, func}, 32'h20);
    cyc(c_decode(), 32'h0);
    cyc(c_exec(1'b0, 3'b010), 32'h0);
    cyc(c_wb(1'b1, 1'b0), 32'h0);
    peek(5'd3); chk("add_rf3", dbg_data, 32'd12);

    // lw $4,0x40($0) then sw $4,0x40($0)
    cyc(c_fetch(), 32'h8C04_0040);
    cyc(c_decode(), 32'h0);
    cyc(c_exec(1'b1, 3'b010), 32'h0);
    k = '0; k.iord = 1; k.wdr = 1;
    drive(k, 32'hDEAD_BEEF, 1'b0);
    chk("lw_addr", mem_addr, 32'h40);
    tick();
    cyc(c_wb(1'b0, 1'b1), 32'h0);
    peek(5'd4); chk("lw_rf4", dbg_data, 32'hDEAD_BEEF);
    cyc(c_fetch(), 32'hAC04_0040);
    cyc(c_decode(), 32'h0);
    cyc(c_exec(1'b1, 3'b010), 32'h0);
    k = '0; k.iord = 1; k.wmem = 1;
    drive(k, 32'h0, 1'b0);
    chk("sw_addr", mem_addr, 32'h40);
    chk("sw_we", {31'b0, mem_we}, 32'h1);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();

    // beq $1,$2 taken, then not taken, then j.
    run_addi(32'h2002_0005);
    jump_via(32'h0800_0003);
    chk("jump_pc_0c", pc_out, 32'h0C);
    cyc(c_fetch(), 32'h1022_0003);
    chk("beq_fetch_pc", pc_out, 32'h10);
    cyc(c_decode(), 32'h0);
    k = '0; k.aluc = 3'b110; k.wpc = 1; k.pcs = 2'b01;
    drive(k, 32'h0, 1'b0);
    chk("beq_zero_taken", {31'b0, Zero}, 32'h1);
    tick();
    chk("beq_pc_taken", pc_out, 32'h1C);
    run_addi(32'h2002_0008);
    jump_via(32'h0800_0003);
    cyc(c_fetch(), 32'h1022_0003);
    cyc(c_decode(), 32'h0);
    k = '0; k.aluc = 3'b110;
    drive(k, 32'h0, 1'b0);
    chk("beq_zero_not", {31'b0, Zero}, 32'h0);
    tick();
    chk("beq_pc_not", pc_out, 32'h10);
    jump_via(32'h0800_0010);
    chk("j_pc", pc_out, 32'h40);

    // Write to $0 is dropped; WriteA alongside a write to $1 sees the old $1.
    run_addi(32'h2000_0009);
    peek(5'd0); chk("rf0_zero", dbg_data, 32'h0);
    cyc(c_fetch(), 32'h2021_0020);
    cyc(c_exec(1'b1, 3'b010), 32'h0);
    k = c_wb(1'b0, 1'b0); k.wa = 1;
    cyc(k, 32'h0);
    k = '0; k.wpc = 1; k.pcs = 2'b11;
    cyc(k, 32'h0);
    chk("bypass_old_a", pc_out, 32'd5);
    peek(5'd1); chk("bypass_rf1", dbg_data, 32'h20);

    // Reset mid-instruction discards WriteReg/WritePC.
    cyc(c_fetch(), 32'h2003_0077);
    cyc(c_decode(), 32'h0);
    cyc(c_exec(1'b1, 3'b010), 32'h0);
    k = c_wb(1'b0, 1'b0); k.wpc = 1;
    drive(k, 32'h0, 1'b1); tick();
    peek(5'd3); chk("abort_rf3", dbg_data, 32'h0);
    chk("abort_pc", pc_out, 32'h0);

    // ALU vector table, using shamt and immediate operands.
    foreach (tv[i]) begin
      k = '0; k.wir = 1;
      cyc(k, tv[i].ir);
      k = '0; k.srca = 1; k.srcb = 1; k.aluc = tv[i].aluc; k.wc = 1;
      drive(k, 32'h0, 1'b0);
      chk("alu_zero", {31'b0, Zero}, {31'b0, tv[i].res == 32'd0});
      tick();
      k = '0; k.iord = 1;
      drive(k, 32'h0, 1'b0);
      chk("alu_res", mem_addr, tv[i].res);
      tick();
    end

    // Random control streams against the model.
    for (int i = 0; i < 600; i++) begin
      rv = 18'($urandom);
      k = rv;
      dbg_sel = 5'($urandom);
      drive(k, $urandom, ($urandom_range(0, 63) == 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
